// File: rtl/decoder_seq_onehot_pkg.sv
// Shared definitions for the sequenced one-hot decoder: mode encodings,
// FSM state type and a small constant helper used for counter sizing.
package decoder_seq_onehot_pkg;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_PULSE  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_PULSE = 2'd2,
    ST_SCAN  = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decoder_seq_onehot_onehot_dec.sv
// Combinational SEL_W-bit index to 2**SEL_W one-hot decoder.
module onehot_dec #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [(1<<SEL_W)-1:0] onehot
);

  localparam int OUT_W = 1 << SEL_W;

  // Shift a single one into position idx.
  always_comb begin
    onehot = {{(OUT_W-1){1'b0}}, 1'b1} << idx;
  end

endmodule

// File: rtl/decoder_seq_onehot.sv
// Registered binary-to-one-hot decoder with load handshake and three output
// modes: static hold, timed pulse and (optionally) auto-scan.
// Build option: define DECODER_SCAN_EN to include the SCAN mode and its dwell
// logic; without it, a SCAN request is rejected like the reserved mode.
module decoder_seq_onehot
  import decoder_seq_onehot_pkg::*;
#(
  parameter int SEL_W      = 4,
  parameter int PULSE_LEN  = 4,
  parameter int SCAN_DWELL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel,
  input  logic [1:0]            mode,
  output logic [(1<<SEL_W)-1:0] dout,
  output logic                  dout_vld,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  err
);

  localparam int OUT_W = 1 << SEL_W;
  localparam int CNT_W = $clog2(max_int(PULSE_LEN, SCAN_DWELL)) + 1;
  localparam logic [CNT_W-1:0] PULSE_RELOAD = CNT_W'(PULSE_LEN - 1);
`ifdef DECODER_SCAN_EN
  localparam logic [CNT_W-1:0] SCAN_RELOAD  = CNT_W'(SCAN_DWELL - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_d;
  logic             on_d;
  logic             busy_d;
  logic             err_d;
  logic             accept;
  logic [OUT_W-1:0] dec_onehot;
  logic [OUT_W-1:0] dout_d;

  // The decoder works on the next index so dout is registered alongside it.
  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx    (idx_d),
    .onehot (dec_onehot)
  );

  // Next-state: timed progression first, then an accepted load overrides it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx;
    on_d    = dout_vld;
    busy_d  = busy;
    err_d   = 1'b0;
    accept  = load && !busy;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      on_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_PULSE: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            on_d    = 1'b0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
`ifdef DECODER_SCAN_EN
        ST_SCAN: begin
          if (cnt_q == '0) begin
            idx_d = idx + 1'b1;
            cnt_d = SCAN_RELOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
`endif
        default: ;
      endcase

      if (accept) begin
        case (mode)
          MODE_STATIC: begin
            state_d = ST_HOLD;
            idx_d   = sel;
            on_d    = 1'b1;
            cnt_d   = '0;
          end
          MODE_PULSE: begin
            state_d = ST_PULSE;
            idx_d   = sel;
            on_d    = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = PULSE_RELOAD;
          end
`ifdef DECODER_SCAN_EN
          MODE_SCAN: begin
            state_d = ST_SCAN;
            idx_d   = sel;
            on_d    = 1'b1;
            cnt_d   = SCAN_RELOAD;
          end
`endif
          default: err_d = 1'b1;
        endcase
      end
    end

    dout_d = on_d ? dec_onehot : '0;
  end

  // State and output registers; reset aborts any operation at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx      <= idx_d;
      dout     <= dout_d;
      dout_vld <= on_d;
      busy     <= busy_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_decoder_seq_onehot.sv
// Self-checking bench for decoder_seq_onehot (default parameters).
// Expected outputs come from a behavioural model and are queued per cycle.
module tb_decoder_seq_onehot;

  localparam int SEL_W      = 4;
  localparam int OUT_W      = 16;
  localparam int PULSE_LEN  = 4;
  localparam int SCAN_DWELL = 2;
`ifdef DECODER_SCAN_EN
  localparam bit SCAN_ON = 1'b1;
`else
  localparam bit SCAN_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             load;
  logic [SEL_W-1:0] sel;
  logic [1:0]       mode;
  logic [OUT_W-1:0] dout;
  logic             dout_vld;
  logic [SEL_W-1:0] idx;
  logic             busy;
  logic             err;

  decoder_seq_onehot #(
    .SEL_W(SEL_W), .PULSE_LEN(PULSE_LEN), .SCAN_DWELL(SCAN_DWELL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .sel(sel), .mode(mode),
    .dout(dout), .dout_vld(dout_vld), .idx(idx), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] dout;
    logic             vld;
    logic [SEL_W-1:0] idx;
    logic             busy;
    logic             err;
  } exp_t;

  exp_t sb_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: 0 idle, 1 hold, 2 pulse, 3 scan
  int m_st  = 0;
  int m_idx = 0;
  int m_cnt = 0;
  bit m_on  = 1'b0;
  bit m_busy = 1'b0;
  bit m_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_cnt = 0; m_on = 1'b0; m_busy = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit l, input int s, input int md);
    bit acc;
    m_err = 1'b0;
    if (!e) begin
      model_reset();
      return;
    end
    acc = l && !m_busy;
    if (m_st == 2) begin
      if (m_cnt == 0) begin m_st = 0; m_on = 1'b0; m_idx = 0; m_busy = 1'b0; end
      else m_cnt--;
    end else if (m_st == 3) begin
      if (m_cnt == 0) begin m_idx = (m_idx + 1) % OUT_W; m_cnt = SCAN_DWELL - 1; end
      else m_cnt--;
    end
    if (acc) begin
      if (md == 0) begin
        m_st = 1; m_idx = s; m_on = 1'b1; m_cnt = 0;
      end else if (md == 1) begin
        m_st = 2; m_idx = s; m_on = 1'b1; m_busy = 1'b1; m_cnt = PULSE_LEN - 1;
      end else if (md == 2 && SCAN_ON) begin
        m_st = 3; m_idx = s; m_on = 1'b1; m_cnt = SCAN_DWELL - 1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    x.dout = m_on ? (OUT_W'(1) << m_idx) : '0;
    x.vld  = m_on;
    x.idx  = m_on ? SEL_W'(m_idx) : '0;
    x.busy = m_busy;
    x.err  = m_err;
    return x;
  endfunction

  // Drive one cycle of stimulus, queue the expected result, compare after the edge.
  task automatic step(input bit e, input bit l, input int s, input int md);
    exp_t x;
    en = e; load = l; sel = SEL_W'(s); mode = 2'(md);
    model_step(e, l, s, md);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_assert++; n_fail++;
      $display("FAIL sb_empty: got 0 entries, expected 1");
    end else begin
      x = sb_q.pop_front();
      check_eq("dout", 32'(dout), 32'(x.dout));
      check_eq("dout_vld", 32'(dout_vld), 32'(x.vld));
      check_eq("idx", 32'(idx), 32'(x.idx));
      check_eq("busy", 32'(busy), 32'(x.busy));
      check_eq("err", 32'(err), 32'(x.err));
    end
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0);
  endtask

  logic [OUT_W-1:0] scan_exp [8] = '{16'h4000, 16'h4000, 16'h8000, 16'h8000,
                                     16'h0001, 16'h0001, 16'h0002, 16'h0002};

  initial begin
    int pulse_on;
    int pulse_busy;

    rst = 1'b1; en = 1'b0; load = 1'b0; sel = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_vld", 32'(dout_vld), 32'h0);
    check_eq("rst_idx", 32'(idx), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    model_reset();
    idle_steps(2);

    // STATIC hold of index 5
    step(1'b1, 1'b1, 5, 0);
    check_eq("static_dout", 32'(dout), 32'h0020);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 9, 1);
      check_eq("static_held", 32'(dout), 32'h0020);
    end

    // en low beats a simultaneous load
    step(1'b0, 1'b1, 3, 0);
    check_eq("en_drop_dout", 32'(dout), 32'h0);
    check_eq("en_drop_vld", 32'(dout_vld), 32'h0);
    idle_steps(2);

    // PULSE on index 15 with an ignored load in the middle
    pulse_on = 0; pulse_busy = 0;
    step(1'b1, 1'b1, 15, 1);
    if (dout == 16'h8000) pulse_on++;
    if (busy) pulse_busy++;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i == 1), 2, 0);
      if (dout == 16'h8000) pulse_on++;
      if (busy) pulse_busy++;
    end
    check_eq("pulse_len", 32'(pulse_on), 32'(PULSE_LEN));
    check_eq("pulse_busy", 32'(pulse_busy), 32'(PULSE_LEN));
    check_eq("pulse_end", 32'(dout), 32'h0);

    // Reserved mode while holding index 7
    step(1'b1, 1'b1, 7, 0);
    step(1'b1, 1'b1, 1, 3);
    check_eq("rsvd_dout", 32'(dout), 32'h0080);
    check_eq("rsvd_err", 32'(err), 32'h1);
    step(1'b1, 1'b0, 0, 0);
    check_eq("rsvd_err_clr", 32'(err), 32'h0);

`ifdef DECODER_SCAN_EN
    // SCAN from 14 with wrap, then stopped by a STATIC load of 0
    step(1'b1, 1'b1, 14, 2);
    check_eq("scan_0", 32'(dout), 32'(scan_exp[0]));
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, 0, 0);
      check_eq($sformatf("scan_%0d", i), 32'(dout), 32'(scan_exp[i]));
    end
    step(1'b1, 1'b1, 0, 0);
    idle_steps(3);
    check_eq("scan_stop", 32'(dout), 32'h0001);
`else
    // SCAN compiled out: rejected like the reserved mode
    step(1'b1, 1'b1, 14, 2);
    check_eq("noscan_dout", 32'(dout), 32'h0080);
    check_eq("noscan_err", 32'(err), 32'h1);
    idle_steps(1);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, OUT_W - 1), $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of an active operation
`ifdef DECODER_SCAN_EN
    step(1'b1, 1'b1, 9, 2);
`else
    step(1'b1, 1'b1, 9, 1);
`endif
    step(1'b1, 1'b0, 0, 0);
    check_eq("pre_rst_vld", 32'(dout_vld), 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst_dout", 32'(dout), 32'h0);
    check_eq("arst_busy", 32'(busy), 32'h0);
    check_eq("arst_idx", 32'(idx), 32'h0);
    check_eq("arst_vld", 32'(dout_vld), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle_steps(2);
    step(1'b1, 1'b1, 3, 0);
    check_eq("post_rst_dout", 32'(dout), 32'h0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
